// File: rtl/lopd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lopd_norm_pipe
// Description : Two-stage leading/trailing-one detector with normalising shift
//               and valid/ready handshake, for the FP add/sub datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module lopd_norm_pipe #(
  parameter  int WIDTH   = 24,
  parameter  int GROUP_W = 8,
  parameter  int TAG_W   = 4,
  localparam int POS_W   = $clog2(WIDTH),
  localparam int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_dir,
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [POS_W-1:0]   o_pos,
  output logic [CNT_W-1:0]   o_cnt,
  output logic [WIDTH-1:0]   o_norm,
  output logic               o_zero,
  output logic               o_dir,
  output logic [TAG_W-1:0]   o_tag
);

  localparam int NG     = WIDTH / GROUP_W;
  localparam int GPOS_W = $clog2(GROUP_W);

  // Stage 1 combinational: group-local zero flag and one-position
  logic [NG-1:0]        grp_zero;
  logic [NG*GPOS_W-1:0] grp_pos;

  generate
    for (genvar g = 0; g < NG; g++) begin : g_group
      logic [GROUP_W-1:0] sh;
      logic [GPOS_W-1:0]  lpos;
      logic               found;

      // Ascending scan: last hit is MSB-most, first hit is LSB-most.
      always_comb begin
        sh    = i_data[g*GROUP_W +: GROUP_W];
        lpos  = '0;
        found = 1'b0;
        for (int b = 0; b < GROUP_W; b++) begin
          if (sh[0] && (!i_dir || !found)) begin
            lpos  = GPOS_W'(b);
            found = 1'b1;
          end
          sh = sh >> 1;
        end
      end

      assign grp_zero[g]                    = ~|i_data[g*GROUP_W +: GROUP_W];
      assign grp_pos[g*GPOS_W +: GPOS_W]    = lpos;
    end
  endgenerate

  // Stage 1 registers
  logic                 s1_v;
  logic [WIDTH-1:0]     s1_data;
  logic                 s1_dir;
  logic [TAG_W-1:0]     s1_tag;
  logic [NG-1:0]        s1_zero;
  logic [NG*GPOS_W-1:0] s1_pos;

  // Stage 2 combinational: group select, count and shift
  logic [NG-1:0]        zv;
  logic [NG*GPOS_W-1:0] pv;
  logic [POS_W-1:0]     sel_pos;
  logic                 hit;
  logic                 all_zero;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     norm;

  always_comb begin
    zv      = s1_zero;
    pv      = s1_pos;
    sel_pos = '0;
    hit     = 1'b0;
    for (int g = 0; g < NG; g++) begin
      if (!zv[0] && (!s1_dir || !hit)) begin
        sel_pos = POS_W'(g * GROUP_W) + POS_W'(pv[GPOS_W-1:0]);
        hit     = 1'b1;
      end
      zv = zv >> 1;
      pv = pv >> GPOS_W;
    end
  end

  assign all_zero = &s1_zero;

  always_comb begin
    cnt  = '0;
    norm = '0;
    if (all_zero) begin
      cnt = CNT_W'(WIDTH);
    end else if (s1_dir) begin
      cnt  = CNT_W'(sel_pos);
      norm = s1_data >> cnt;
    end else begin
      cnt  = CNT_W'(WIDTH - 1) - CNT_W'(sel_pos);
      norm = s1_data << cnt;
    end
  end

  // Handshake: S2 frees when empty or consumed; S1 frees when empty or S2 frees
  logic adv2;
  logic load1;

  assign adv2    = !o_valid || i_ready;
  assign o_ready = !s1_v || adv2;
  assign load1   = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_dir  <= 1'b0;
      s1_tag  <= '0;
      s1_zero <= '0;
      s1_pos  <= '0;
      o_valid <= 1'b0;
      o_pos   <= '0;
      o_cnt   <= '0;
      o_norm  <= '0;
      o_zero  <= 1'b0;
      o_dir   <= 1'b0;
      o_tag   <= '0;
    end else begin
      if (o_ready) begin
        s1_v <= i_valid;
      end
      if (load1) begin
        s1_data <= i_data;
        s1_dir  <= i_dir;
        s1_tag  <= i_tag;
        s1_zero <= grp_zero;
        s1_pos  <= grp_pos;
      end
      if (adv2) begin
        o_valid <= s1_v;
      end
      // Output registers only change when a real beat moves in.
      if (adv2 && s1_v) begin
        o_pos  <= sel_pos;
        o_cnt  <= cnt;
        o_norm <= norm;
        o_zero <= all_zero;
        o_dir  <= s1_dir;
        o_tag  <= s1_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lopd_norm_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lopd_norm_pipe
// Description : Self-checking bench; two configurations (24/8 and 16/4) driven
//               in lockstep against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lopd_norm_pipe;

  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_dir = 1'b0;
  logic          i_ready = 1'b1;
  logic [23:0]   i_data = '0;
  logic [TW-1:0] i_tag = '0;

  logic          o_ready_a, o_valid_a, o_zero_a, o_dir_a;
  logic [4:0]    o_pos_a;
  logic [4:0]    o_cnt_a;
  logic [23:0]   o_norm_a;
  logic [TW-1:0] o_tag_a;

  logic          o_ready_b, o_valid_b, o_zero_b, o_dir_b;
  logic [3:0]    o_pos_b;
  logic [4:0]    o_cnt_b;
  logic [15:0]   o_norm_b;
  logic [TW-1:0] o_tag_b;

  lopd_norm_pipe #(.WIDTH(24), .GROUP_W(8), .TAG_W(TW)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_data(i_data), .i_dir(i_dir), .i_tag(i_tag), .o_valid(o_valid_a),
    .i_ready(i_ready), .o_pos(o_pos_a), .o_cnt(o_cnt_a), .o_norm(o_norm_a),
    .o_zero(o_zero_a), .o_dir(o_dir_a), .o_tag(o_tag_a)
  );

  lopd_norm_pipe #(.WIDTH(16), .GROUP_W(4), .TAG_W(TW)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_data(i_data[15:0]), .i_dir(i_dir), .i_tag(i_tag), .o_valid(o_valid_b),
    .i_ready(i_ready), .o_pos(o_pos_b), .o_cnt(o_cnt_b), .o_norm(o_norm_b),
    .o_zero(o_zero_b), .o_dir(o_dir_b), .o_tag(o_tag_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]   data;
    logic          dir;
    logic [TW-1:0] tag;
    int            c;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    accepted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Count zeros from the scanned end of the low w bits of d
  function automatic void ref_model(input logic [63:0] d_in, input logic dir, input int w,
                                    output int pos, output int cnt,
                                    output logic [63:0] norm, output bit zero);
    logic [63:0] m;
    logic [63:0] d;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d    = d_in & m;
    zero = (d == 64'd0);
    pos  = 0;
    cnt  = w;
    norm = '0;
    if (!zero) begin
      if (!dir) begin
        cnt = 0;
        while (((d << cnt) & (64'd1 << (w - 1))) == 64'd0) cnt++;
        pos  = w - 1 - cnt;
        norm = (d << cnt) & m;
      end else begin
        cnt = 0;
        while (((d >> cnt) & 64'd1) == 64'd0) cnt++;
        pos  = cnt;
        norm = d >> cnt;
      end
    end
  endfunction

  task automatic check_front();
    int p, c;
    logic [63:0] n;
    bit z;
    ref_model(64'(sb[0].data), sb[0].dir, 24, p, c, n, z);
    chk("pos24",  64'(o_pos_a),  64'(p));
    chk("cnt24",  64'(o_cnt_a),  64'(c));
    chk("norm24", 64'(o_norm_a), n);
    chk("zero24", 64'(o_zero_a), 64'(z));
    chk("dir24",  64'(o_dir_a),  64'(sb[0].dir));
    chk("tag24",  64'(o_tag_a),  64'(sb[0].tag));
    ref_model(64'(sb[0].data), sb[0].dir, 16, p, c, n, z);
    chk("pos16",  64'(o_pos_b),  64'(p));
    chk("cnt16",  64'(o_cnt_b),  64'(c));
    chk("norm16", 64'(o_norm_b), n);
    chk("zero16", 64'(o_zero_b), 64'(z));
    chk("dir16",  64'(o_dir_b),  64'(sb[0].dir));
    chk("tag16",  64'(o_tag_b),  64'(sb[0].tag));
  endtask

  // Called one unit after a rising edge with inputs already driven
  task automatic cycle();
    bit ev, er;
    #1;
    ev = (sb.size() > 0) && (cyc >= sb[0].c + 2);
    er = (sb.size() < 2) || i_ready;
    chk("o_valid24", 64'(o_valid_a), 64'(ev));
    chk("o_valid16", 64'(o_valid_b), 64'(ev));
    chk("o_ready24", 64'(o_ready_a), 64'(er));
    chk("o_ready16", 64'(o_ready_b), 64'(er));
    if (ev) check_front();
    accepted = i_valid && er;
    if (ev && i_ready) sb.delete(0);
    if (accepted) sb.push_back('{i_data, i_dir, i_tag, cyc});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_reset_state();
    chk("rst_valid24", 64'(o_valid_a), 64'd0);
    chk("rst_pos24",   64'(o_pos_a),   64'd0);
    chk("rst_cnt24",   64'(o_cnt_a),   64'd0);
    chk("rst_norm24",  64'(o_norm_a),  64'd0);
    chk("rst_zero24",  64'(o_zero_a),  64'd0);
    chk("rst_dir24",   64'(o_dir_a),   64'd0);
    chk("rst_tag24",   64'(o_tag_a),   64'd0);
    chk("rst_ready24", 64'(o_ready_a), 64'd1);
    chk("rst_valid16", 64'(o_valid_b), 64'd0);
    chk("rst_norm16",  64'(o_norm_b),  64'd0);
    chk("rst_cnt16",   64'(o_cnt_b),   64'd0);
    chk("rst_ready16", 64'(o_ready_b), 64'd1);
  endtask

  task automatic send(input logic [23:0] d, input logic dir, input logic [TW-1:0] tag);
    i_valid = 1'b1;
    i_data  = d;
    i_dir   = dir;
    i_tag   = tag;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (accepted) break;
    end
    chk("send_accept", 64'(accepted), 64'd1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (sb.size() == 0) break;
      cycle();
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    cycle();
  endtask

  function automatic logic [23:0] rnd_data();
    logic [23:0] r;
    int k;
    r = 24'($urandom);
    k = int'($urandom_range(0, 23));
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return r >> k;
      2:       return r << k;
      default: return r;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int sent;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset_state();

    // Directed vectors: leading/trailing one, MSB edge, all zero both directions
    send(24'h000100, 1'b0, 4'd1);
    send(24'h000120, 1'b1, 4'd2);
    send(24'h008000, 1'b0, 4'd3);
    send(24'h000000, 1'b0, 4'd4);
    send(24'h000000, 1'b1, 4'd5);
    send(24'h800001, 1'b0, 4'd6);
    send(24'h800001, 1'b1, 4'd7);
    drain();

    // Backpressure: six back-to-back beats, downstream stalled in cycles 3..8
    sent = 0;
    for (int k = 0; k < 60; k++) begin
      i_ready = !(k >= 3 && k <= 8);
      i_valid = (sent < 6);
      i_tag   = TW'(sent);
      i_data  = 24'h000F00 >> sent;
      i_dir   = sent[0];
      cycle();
      if (accepted) sent++;
      if (sent == 6 && sb.size() == 0) break;
    end
    chk("bp_sent", 64'(sent), 64'd6);
    drain();

    // Full throughput: 20 random beats with downstream always ready
    sent    = 0;
    i_ready = 1'b1;
    while (sent < 20) begin
      i_valid = 1'b1;
      i_data  = rnd_data();
      i_dir   = 1'($urandom_range(0, 1));
      i_tag   = TW'(sent);
      cycle();
      if (accepted) sent++;
    end
    drain();

    // Reset while both stages are full
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (sb.size() == 2) break;
      i_data = rnd_data();
      i_tag  = TW'(k + 8);
      cycle();
    end
    chk("fill_before_reset", 64'(sb.size()), 64'd2);
    rst     = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    chk_reset_state();
    i_ready = 1'b1;
    repeat (2) cycle();
    send(24'h004000, 1'b0, 4'hA);
    drain();

    // Random valid/ready traffic
    for (int k = 0; k < 300; k++) begin
      if (!i_valid || accepted) begin
        i_valid = 1'($urandom_range(0, 3) != 0);
        i_data  = rnd_data();
        i_dir   = 1'($urandom_range(0, 1));
        i_tag   = TW'($urandom);
      end
      i_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
